// File: rtl/multichannel_fir_mac_if.sv
// ----------------------------------------------------------------------------
// multichannel_fir_mac_if
//   Bundles the frame handshake, coefficient write port and status outputs of
//   multichannel_fir_mac. clk/rst stay plain ports on the design.
//
//   slave  modport : the filter (consumes frames and coefficient writes)
//   master modport : the producer / host side
//
//   sw            filter select, one-hot over the coefficient banks
//   in_valid/in_ready/in_data     frame input handshake, ch c at [c*DW +: DW]
//   out_valid/out_data            one-cycle result pulse, data held after it
//   coef_we/coef_filt/coef_addr/coef_data   coefficient write port
//   busy, active_filter, sat_flag status
// ----------------------------------------------------------------------------
interface multichannel_fir_mac_if #(
  parameter int DATA_WIDTH  = 24,
  parameter int COEFF_WIDTH = 16,
  parameter int N_TAPS      = 89,
  parameter int N_CHANNELS  = 2,
  parameter int N_FILTERS   = 4
);
  localparam int FW  = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;
  localparam int TW  = $clog2(N_TAPS);
  localparam int AFW = $clog2(N_FILTERS + 1);

  logic [N_FILTERS-1:0]             sw;
  logic                             in_valid;
  logic                             in_ready;
  logic [N_CHANNELS*DATA_WIDTH-1:0] in_data;
  logic                             out_valid;
  logic [N_CHANNELS*DATA_WIDTH-1:0] out_data;
  logic                             coef_we;
  logic [FW-1:0]                    coef_filt;
  logic [TW-1:0]                    coef_addr;
  logic [COEFF_WIDTH-1:0]           coef_data;
  logic                             busy;
  logic [AFW-1:0]                   active_filter;
  logic                             sat_flag;

  modport slave (
    input  sw, in_valid, in_data, coef_we, coef_filt, coef_addr, coef_data,
    output in_ready, out_valid, out_data, busy, active_filter, sat_flag
  );

  modport master (
    output sw, in_valid, in_data, coef_we, coef_filt, coef_addr, coef_data,
    input  in_ready, out_valid, out_data, busy, active_filter, sat_flag
  );
endinterface

// File: rtl/multichannel_fir_mac.sv
// ----------------------------------------------------------------------------
// multichannel_fir_mac
//   Time-multiplexed N-channel FIR filter built around one shared
//   multiply-accumulate. Each channel keeps a circular history of N_TAPS
//   samples; N_FILTERS coefficient banks are loadable at runtime. Results are
//   rounded half-up, arithmetically shifted by OUT_SHIFT and saturated to the
//   sample width. A zero or non-one-hot select bypasses the filter.
//
//   clk   rising-edge clock
//   rst   synchronous active-high reset; restarts the history clear
//   bus   multichannel_fir_mac_if.slave (handshake, coefficient port, status)
// ----------------------------------------------------------------------------
module multichannel_fir_mac #(
  parameter int DATA_WIDTH  = 24,
  parameter int COEFF_WIDTH = 16,
  parameter int N_TAPS      = 89,
  parameter int N_CHANNELS  = 2,
  parameter int N_FILTERS   = 4,
  parameter int OUT_SHIFT   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  multichannel_fir_mac_if.slave   bus
);

  localparam int FW    = (N_FILTERS > 1) ? $clog2(N_FILTERS) : 1;
  localparam int TW    = $clog2(N_TAPS);
  localparam int CHW   = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int AFW   = $clog2(N_FILTERS + 1);
  localparam int PW    = DATA_WIDTH + COEFF_WIDTH;
  localparam int ACC_W = DATA_WIDTH + COEFF_WIDTH + $clog2(N_TAPS);

  localparam logic [TW-1:0]  LAST_TAP = TW'(N_TAPS - 1);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(N_CHANNELS - 1);

  // Rounding and clip constants, one bit wider than the accumulator so the
  // half-LSB add can never wrap.
  localparam logic signed [ACC_W:0] RND  = (ACC_W + 1)'(1) << (OUT_SHIFT - 1);
  localparam logic signed [ACC_W:0] MAXV =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, 1'b0, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W:0] MINV =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, 1'b1, {(DATA_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_MAC, S_ROUND} state_e;

  state_e                           state_q;
  logic [TW-1:0]                    clr_q;
  logic [TW-1:0]                    ptr_q;
  logic [TW-1:0]                    rd_q;
  logic [TW-1:0]                    k_q;
  logic [CHW-1:0]                   c_q;
  logic [FW-1:0]                    bank_q;
  logic signed [ACC_W-1:0]          acc_q;
  logic                             sat_any_q;
  logic                             in_ready_q;
  logic                             busy_q;
  logic                             out_valid_q;
  logic [N_CHANNELS*DATA_WIDTH-1:0] out_data_q;
  logic [AFW-1:0]                   active_filter_q;
  logic                             sat_flag_q;

  logic signed [COEFF_WIDTH-1:0] coef_mem [N_FILTERS][N_TAPS];
  logic signed [DATA_WIDTH-1:0]  hist_mem [N_CHANNELS][N_TAPS];

  // ---------------------------------------------------------------- select
  // sw is MSB-first over banks: the top bit selects bank 0.
  logic [FW-1:0] sel_bank;
  logic          sel_valid;

  always_comb begin
    sel_bank = '0;
    for (int f = 0; f < N_FILTERS; f++) begin
      if (bus.sw[N_FILTERS-1-f]) sel_bank = FW'(f);
    end
  end

  assign sel_valid = $onehot(bus.sw);

  // ------------------------------------------------------------- datapath
  logic signed [PW-1:0]         prod;
  logic signed [ACC_W:0]        acc_rnd;
  logic signed [ACC_W:0]        acc_shr;
  logic signed [DATA_WIDTH-1:0] y_sat;
  logic                         y_clip;
  logic [TW-1:0]                ptr_nxt;
  logic [TW-1:0]                rd_prev;

  assign prod    = coef_mem[bank_q][k_q] * hist_mem[c_q][rd_q];
  assign acc_rnd = {acc_q[ACC_W-1], acc_q} + RND;
  assign acc_shr = acc_rnd >>> OUT_SHIFT;
  assign ptr_nxt = (ptr_q == LAST_TAP) ? '0 : ptr_q + TW'(1);
  // History is walked backwards from the newest sample: x[n-k].
  assign rd_prev = (rd_q == '0) ? LAST_TAP : rd_q - TW'(1);

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (here via the final else) so no latch is inferred.
  always_comb begin
    if (acc_shr > MAXV) begin
      y_sat  = MAXV[DATA_WIDTH-1:0];
      y_clip = 1'b1;
    end else if (acc_shr < MINV) begin
      y_sat  = MINV[DATA_WIDTH-1:0];
      y_clip = 1'b1;
    end else begin
      y_sat  = acc_shr[DATA_WIDTH-1:0];
      y_clip = 1'b0;
    end
  end

  // -------------------------------------------------------------- memories
  // NOTE: the storage arrays carry no reset; coefficients must survive rst and
  // the history is wiped by the CLEAR sweep, so a reset net would only cost
  // the ability to map them onto RAM.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.coef_we &&
        32'(bus.coef_filt) < 32'(N_FILTERS) && 32'(bus.coef_addr) < 32'(N_TAPS)) begin
      coef_mem[bus.coef_filt][bus.coef_addr] <= bus.coef_data;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      for (int c = 0; c < N_CHANNELS; c++) hist_mem[c][clr_q] <= '0;
    end else if (state_q == S_IDLE && bus.in_valid) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        hist_mem[c][ptr_q] <= bus.in_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // ------------------------------------------------------------------- FSM
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_CLEAR;
      clr_q           <= '0;
      ptr_q           <= '0;
      rd_q            <= '0;
      k_q             <= '0;
      c_q             <= '0;
      bank_q          <= '0;
      acc_q           <= '0;
      sat_any_q       <= 1'b0;
      in_ready_q      <= 1'b0;
      busy_q          <= 1'b1;
      out_valid_q     <= 1'b0;
      out_data_q      <= '0;
      active_filter_q <= '0;
      sat_flag_q      <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        S_CLEAR: begin
          if (clr_q == LAST_TAP) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            clr_q <= clr_q + TW'(1);
          end
        end

        S_IDLE: begin
          if (bus.in_valid) begin
            if (sel_valid) begin
              bank_q          <= sel_bank;
              active_filter_q <= AFW'(sel_bank) + AFW'(1);
              state_q         <= S_MAC;
              in_ready_q      <= 1'b0;
              busy_q          <= 1'b1;
              k_q             <= '0;
              c_q             <= '0;
              rd_q            <= ptr_q;
              acc_q           <= '0;
              sat_any_q       <= 1'b0;
            end else begin
              // Bypass completes in the accept cycle; ptr still advances so
              // the history stays contiguous for later filtered frames.
              active_filter_q <= '0;
              out_data_q      <= bus.in_data;
              out_valid_q     <= 1'b1;
              sat_flag_q      <= 1'b0;
              ptr_q           <= ptr_nxt;
            end
          end
        end

        S_MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          rd_q  <= rd_prev;
          if (k_q == LAST_TAP) state_q <= S_ROUND;
          else                 k_q     <= k_q + TW'(1);
        end

        S_ROUND: begin
          out_data_q[c_q*DATA_WIDTH +: DATA_WIDTH] <= y_sat;
          acc_q <= '0;
          if (c_q == LAST_CH) begin
            out_valid_q <= 1'b1;
            sat_flag_q  <= sat_any_q | y_clip;
            ptr_q       <= ptr_nxt;
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end else begin
            sat_any_q <= sat_any_q | y_clip;
            c_q       <= c_q + CHW'(1);
            k_q       <= '0;
            rd_q      <= ptr_q;
            state_q   <= S_MAC;
          end
        end

        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.busy          = busy_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.active_filter = active_filter_q;
  assign bus.sat_flag      = sat_flag_q;

endmodule

// File: tb/tb_multichannel_fir_mac.sv
// ----------------------------------------------------------------------------
// tb_multichannel_fir_mac
//   Self-checking bench for multichannel_fir_mac. A reference model holds the
//   coefficient banks and the last N_TAPS samples per channel as plain arrays
//   and queues, and computes each output as a direct convolution sum followed
//   by round-half-up, shift and clip.
// ----------------------------------------------------------------------------
module tb_multichannel_fir_mac;

  localparam int DW   = 24;
  localparam int CW   = 16;
  localparam int N_T  = 89;
  localparam int N_CH = 2;
  localparam int N_F  = 4;
  localparam int SH   = 16;
  localparam int FILT_LAT = N_CH * (N_T + 1) + 1;

  localparam longint YMAX = (longint'(1) <<< (DW - 1)) - 1;
  localparam longint YMIN = -(longint'(1) <<< (DW - 1));

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multichannel_fir_mac_if bus ();

  multichannel_fir_mac dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  longint coef_m [N_F][N_T];
  longint hist_m [N_CH][$];
  longint exp_y  [N_CH];

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint ch_out(input int c);
    logic signed [DW-1:0] s;
    s = bus.out_data[c*DW +: DW];
    return longint'(s);
  endfunction

  function automatic logic [N_CH*DW-1:0] pack2(input longint a, input longint b);
    logic [N_CH*DW-1:0] p;
    p[0 +: DW]  = DW'(a);
    p[DW +: DW] = DW'(b);
    return p;
  endfunction

  function automatic logic [N_CH*DW-1:0] rnd_frame();
    logic [N_CH*DW-1:0] p;
    for (int c = 0; c < N_CH; c++) p[c*DW +: DW] = DW'($urandom);
    return p;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < N_CH; c++) begin
      hist_m[c].delete();
      for (int k = 0; k < N_T; k++) hist_m[c].push_back(0);
    end
  endtask

  task automatic do_reset();
    int cnt;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_busy", bus.busy, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_ch0", ch_out(0), 0);
    check("rst_out_ch1", ch_out(1), 0);
    check("rst_active_filter", bus.active_filter, 0);
    check("rst_sat_flag", bus.sat_flag, 0);
    tick();
    rst = 1'b0;
    cnt = 0;
    while (!bus.in_ready && cnt < 300) begin
      cnt++;
      tick();
    end
    check("clear_ready_low_cycles", cnt, N_T);
    check("clear_busy_after", bus.busy, 0);
    model_clear();
  endtask

  task automatic write_coef(input int f, input int k, input longint v);
    logic signed [CW-1:0] s;
    s = CW'(v);
    bus.coef_we   = 1'b1;
    bus.coef_filt = 2'(f);
    bus.coef_addr = 7'(k);
    bus.coef_data = s;
    tick();
    bus.coef_we = 1'b0;
    if (k < N_T) coef_m[f][k] = longint'(s);
  endtask

  // Offers one frame, optionally with a coefficient write in the accept cycle
  // (wr_acc) and with sw/coef/in_valid disturbances during the MAC (disturb).
  task automatic send_frame(input logic [N_F-1:0] sw_v, input logic [N_CH*DW-1:0] data,
                            input bit disturb, input bit wr_acc);
    int     w, lat, bank, exp_lat;
    bit     bypass, sat;
    longint acc, y;
    logic signed [DW-1:0] xs;
    logic signed [CW-1:0] cs;

    w = 0;
    while (!bus.in_ready && w < 500) begin
      w++;
      tick();
    end
    check("ready_wait", bus.in_ready, 1);

    bypass = !$onehot(sw_v);
    bank = 0;
    for (int f = 0; f < N_F; f++) if (sw_v[N_F-1-f]) bank = f;

    if (wr_acc) begin
      int k;
      k = $urandom_range(0, N_T - 1);
      cs = CW'($urandom);
      bus.coef_we   = 1'b1;
      bus.coef_filt = 2'(bank);
      bus.coef_addr = 7'(k);
      bus.coef_data = cs;
      coef_m[bank][k] = longint'(cs);
    end
    bus.sw       = sw_v;
    bus.in_data  = data;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;

    sat = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      xs = data[c*DW +: DW];
      hist_m[c].push_back(longint'(xs));
      void'(hist_m[c].pop_front());
      if (bypass) begin
        exp_y[c] = longint'(xs);
      end else begin
        acc = 0;
        for (int k = 0; k < N_T; k++) acc += coef_m[bank][k] * hist_m[c][N_T-1-k];
        y = (acc + (longint'(1) <<< (SH - 1))) >>> SH;
        if (y > YMAX) begin y = YMAX; sat = 1'b1; end
        if (y < YMIN) begin y = YMIN; sat = 1'b1; end
        exp_y[c] = y;
      end
    end

    lat = 1;
    while (!bus.out_valid && lat < 1000) begin
      if (disturb && lat == 40) begin
        check("mac_in_ready", bus.in_ready, 0);
        check("mac_busy", bus.busy, 1);
        bus.sw        = ~sw_v;
        bus.coef_we   = 1'b1;
        bus.coef_filt = 2'(bank);
        bus.coef_addr = 7'($urandom_range(0, N_T - 1));
        bus.coef_data = CW'($urandom);
        bus.in_valid  = 1'b1;
        bus.in_data   = rnd_frame();
      end else if (disturb && lat == 41) begin
        bus.coef_we  = 1'b0;
        bus.in_valid = 1'b0;
        bus.sw       = sw_v;
      end
      tick();
      lat++;
    end
    exp_lat = bypass ? 1 : FILT_LAT;
    check("latency", lat, exp_lat);
    for (int c = 0; c < N_CH; c++) check($sformatf("y_ch%0d", c), ch_out(c), exp_y[c]);
    check("sat_flag", bus.sat_flag, bypass ? 0 : longint'(sat));
    check("active_filter", bus.active_filter, bypass ? 0 : bank + 1);

    tick();
    check("out_valid_pulse", bus.out_valid, 0);
    for (int c = 0; c < N_CH; c++) check($sformatf("hold_ch%0d", c), ch_out(c), exp_y[c]);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [N_F-1:0] sw_r;
    bus.sw        = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.coef_we   = 1'b0;
    bus.coef_filt = '0;
    bus.coef_addr = '0;
    bus.coef_data = '0;
    rst = 1'b1;
    tick();

    do_reset();

    for (int k = 0; k < N_T; k++) begin
      write_coef(0, k, k + 1);
      write_coef(1, k, 16'h7FFF);
      write_coef(2, k, (k == 0) ? 1 : 0);
      write_coef(3, k, longint'($urandom_range(0, 65535)) - 32768);
    end
    write_coef(0, 100, 777);
    write_coef(0, 127, -5);

    // Impulse through bank 0 starting from the freshly cleared history.
    for (int j = 0; j <= N_T; j++) begin
      send_frame(4'b1000, pack2((j == 0) ? 65536 : 0, 0), 1'b0, 1'b0);
      check("impulse_ch0", ch_out(0), (j < N_T) ? j + 1 : 0);
      check("impulse_ch1", ch_out(1), 0);
    end

    // Bypass with zero and with non-one-hot select.
    send_frame(4'b0000, pack2(123456, -654321), 1'b0, 1'b0);
    check("bypass0_ch0", ch_out(0), 123456);
    check("bypass0_ch1", ch_out(1), -654321);
    send_frame(4'b0011, pack2(-1, YMAX), 1'b0, 1'b0);
    check("bypass3_ch0", ch_out(0), -1);
    check("bypass3_ch1", ch_out(1), YMAX);

    // Saturation: fill the history via bypass, then one frame through bank 1.
    for (int j = 0; j < N_T - 1; j++) send_frame(4'b0000, pack2(YMAX, YMAX), 1'b0, 1'b0);
    send_frame(4'b0100, pack2(YMAX, YMAX), 1'b0, 1'b0);
    check("sat_pos_ch0", ch_out(0), YMAX);
    check("sat_pos_flag", bus.sat_flag, 1);
    for (int j = 0; j < N_T - 1; j++) send_frame(4'b0000, pack2(YMIN, YMIN), 1'b0, 1'b0);
    send_frame(4'b0100, pack2(YMIN, YMIN), 1'b0, 1'b0);
    check("sat_neg_ch1", ch_out(1), YMIN);
    check("sat_neg_flag", bus.sat_flag, 1);

    // Rounding through bank 2 (h[0]=1 only).
    send_frame(4'b0010, pack2(32768, 32767), 1'b0, 1'b0);
    check("round_32768", ch_out(0), 1);
    check("round_32767", ch_out(1), 0);
    send_frame(4'b0010, pack2(-32768, -32769), 1'b0, 1'b0);
    check("round_m32768", ch_out(0), 0);
    check("round_m32769", ch_out(1), -1);
    check("round_no_sat", bus.sat_flag, 0);

    // Random mix: pointer wraps repeatedly, mid-MAC disturbances, writes at accept.
    for (int j = 0; j < 210; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        sw_r = 4'(1 << $urandom_range(0, N_F - 1));
      end else begin
        do sw_r = 4'($urandom_range(0, 15)); while ($onehot(sw_r));
      end
      send_frame(sw_r, rnd_frame(), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    // Reset in the middle of a filtered frame restarts the clear sweep.
    bus.sw       = 4'b0001;
    bus.in_data  = rnd_frame();
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    repeat (30) tick();
    do_reset();
    send_frame(4'b1000, pack2(65536, 131072), 1'b0, 1'b0);
    check("post_reset_ch0", ch_out(0), 1);
    check("post_reset_ch1", ch_out(1), 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
